// File: rtl/wb_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_queue_if : bus bundle between write-back queue and its users  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface wb_queue_if #(
  parameter int addr_width_p = 6,
  parameter int depth_p      = 4
);
  logic                          alu_wen_i;
  logic [addr_width_p-1:0]       alu_wa_i;
  logic [31:0]                   alu_data_i;
  logic                          mc_valid_i;
  logic [addr_width_p-1:0]       mc_wa_i;
  logic [31:0]                   mc_data_i;
  logic                          mc_ready_o;
  logic                          wen_o;
  logic [addr_width_p-1:0]       wa_o;
  logic [31:0]                   write_data_o;
  logic [(2**addr_width_p)-1:0]  busy_o;
  logic [$clog2(depth_p):0]      count_o;
  logic                          alu_hold_o;

  modport slave (
    input  alu_wen_i, alu_wa_i, alu_data_i,
    input  mc_valid_i, mc_wa_i, mc_data_i,
    output mc_ready_o, wen_o, wa_o, write_data_o,
    output busy_o, count_o, alu_hold_o
  );

  modport master (
    output alu_wen_i, alu_wa_i, alu_data_i,
    output mc_valid_i, mc_wa_i, mc_data_i,
    input  mc_ready_o, wen_o, wa_o, write_data_o,
    input  busy_o, count_o, alu_hold_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_queue : write-back arbiter (ALU first) + in-order mc FIFO      |
// | Optional starvation hold guarded by macro WB_STARVE_GUARD_EN      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wb_queue #(
  parameter int addr_width_p   = 6,
  parameter int depth_p        = 4,
  parameter int starve_limit_p = 8
) (
  input  logic        clk,
  input  logic        reset_n_i,
  wb_queue_if.slave   bus
);

  localparam int c_ptr_w = $clog2(depth_p);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_regs  = 2 ** addr_width_p;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(depth_p);

  if (depth_p < 2 || (depth_p & (depth_p - 1)) != 0 || starve_limit_p < 1) begin : g_param_check
    $error("wb_queue: depth_p must be a power of two >= 2 and starve_limit_p >= 1");
  end

  logic [31:0]             data_q [depth_p];
  logic [addr_width_p-1:0] addr_q [depth_p];
  logic [depth_p-1:0]      valid_q, valid_d;
  logic [c_ptr_w-1:0]      head_q, head_d;
  logic [c_ptr_w-1:0]      tail_q, tail_d;
  logic [c_cnt_w-1:0]      count_q, count_d;

  logic                    wen_q, wen_d;
  logic [addr_width_p-1:0] wa_q, wa_d;
  logic [31:0]             wdata_q, wdata_d;

  logic                    w_empty;
  logic                    w_ready;
  logic                    w_pop;
  logic                    w_bypass;
  logic                    w_enq;
  logic [c_regs-1:0]       w_busy;

  assign w_empty  = (count_q == '0);
  assign w_ready  = reset_n_i && (count_q != c_full);
  assign w_pop    = !bus.alu_wen_i && !w_empty;
  assign w_bypass = !bus.alu_wen_i && w_empty && bus.mc_valid_i;
  assign w_enq    = bus.mc_valid_i && w_ready && !w_bypass;

  // Pop and enqueue never hit the same slot: a pop needs count>0 and an
  // enqueue needs count<depth, so head != tail whenever both fire.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q;
    if (w_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (w_enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({w_enq, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wen_d   = bus.alu_wen_i || w_pop || w_bypass;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    if (bus.alu_wen_i) begin
      wa_d    = bus.alu_wa_i;
      wdata_d = bus.alu_data_i;
    end else if (w_pop) begin
      wa_d    = addr_q[head_q];
      wdata_d = data_q[head_q];
    end else if (w_bypass) begin
      wa_d    = bus.mc_wa_i;
      wdata_d = bus.mc_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by valid_q/count_q.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      data_q[tail_q] <= bus.mc_data_i;
      addr_q[tail_q] <= bus.mc_wa_i;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < depth_p; i++) begin
      if (valid_q[i]) begin
        w_busy[addr_q[i]] = 1'b1;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int c_starve_w = $clog2(starve_limit_p + 1);
  localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(starve_limit_p);

  logic [c_starve_w-1:0] starve_q, starve_d;
  logic                  hold_q, hold_d;

  // With the queue non-empty and no pop, the ALU must be writing, so every
  // such cycle is a blocked cycle for the head entry.
  always_comb begin
    starve_d = starve_q;
    hold_d   = hold_q;
    if (w_pop || w_empty) begin
      starve_d = '0;
      hold_d   = 1'b0;
    end else if (starve_q != c_starve_lim) begin
      starve_d = starve_q + 1'b1;
    end
    if (starve_d == c_starve_lim) begin
      hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.alu_hold_o = hold_q;
`else
  assign bus.alu_hold_o = 1'b0;
`endif

  assign bus.mc_ready_o   = w_ready;
  assign bus.wen_o        = wen_q;
  assign bus.wa_o         = wa_q;
  assign bus.write_data_o = wdata_q;
  assign bus.busy_o       = w_busy;
  assign bus.count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wb_queue : scoreboard bench for wb_queue                       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_wb_queue;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  logic [37:0] exp_q [$];

  wb_queue_if #(.addr_width_p(6), .depth_p(4)) bus_if ();

  wb_queue #(
    .addr_width_p   (6),
    .depth_p        (4),
    .starve_limit_p (8)
  ) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time=%0t required below 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the next expected entry.
  always @(negedge clk) begin
    if (bus_if.wen_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got wa=%0d data=0x%08h expected no write",
                 bus_if.wa_o, bus_if.write_data_o);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        if ({bus_if.wa_o, bus_if.write_data_o} !== e) begin
          fails++;
          $display("FAIL write_order: got wa=%0d data=0x%08h expected wa=%0d data=0x%08h",
                   bus_if.wa_o, bus_if.write_data_o, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic en, input logic [5:0] wa, input logic [31:0] d);
    bus_if.alu_wen_i  = en;
    bus_if.alu_wa_i   = wa;
    bus_if.alu_data_i = d;
    if (en) exp_q.push_back({wa, d});
  endtask

  task automatic mc(input logic v, input logic [5:0] wa, input logic [31:0] d);
    bus_if.mc_valid_i = v;
    bus_if.mc_wa_i    = wa;
    bus_if.mc_data_i  = d;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    alu(1'b0, 6'd0, 32'h0);
    mc(1'b0, 6'd0, 32'h0);

    // Reset and idle
    #1;
    chk("ready_in_reset", {63'h0, bus_if.mc_ready_o}, 64'h0);
    tick();
    tick();
    chk("rst_wen", {63'h0, bus_if.wen_o}, 64'h0);
    chk("rst_wa", {58'h0, bus_if.wa_o}, 64'h0);
    chk("rst_data", {32'h0, bus_if.write_data_o}, 64'h0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_wen", {63'h0, bus_if.wen_o}, 64'h0);
    chk("idle_count", {61'h0, bus_if.count_o}, 64'h0);
    chk("idle_busy", bus_if.busy_o, 64'h0);
    chk("idle_ready", {63'h0, bus_if.mc_ready_o}, 64'h1);
    chk("idle_hold", {63'h0, bus_if.alu_hold_o}, 64'h0);

    // Bypass on empty queue
    mc(1'b1, 6'd5, 32'hDEADBEEF);
    exp_q.push_back({6'd5, 32'hDEADBEEF});
    tick();
    chk("bypass_wen", {63'h0, bus_if.wen_o}, 64'h1);
    chk("bypass_count", {61'h0, bus_if.count_o}, 64'h0);
    mc(1'b0, 6'd0, 32'h0);
    tick();
    chk("bypass_once", {63'h0, bus_if.wen_o}, 64'h0);

    // ALU priority fills the queue
    for (int c = 0; c < 6; c++) begin
      alu(1'b1, 6'(40 + c), 32'hA000_0000 + c);
      if (c < 4) mc(1'b1, 6'(c + 1), 32'h1111_0000 + c + 1);
      else       mc(1'b0, 6'd0, 32'h0);
      tick();
      if (c == 3) begin
        chk("full_count", {61'h0, bus_if.count_o}, 64'h4);
        chk("full_ready", {63'h0, bus_if.mc_ready_o}, 64'h0);
        chk("full_busy", bus_if.busy_o, 64'h1E);
      end
    end
    alu(1'b0, 6'd0, 32'h0);
    for (int k = 1; k <= 4; k++) exp_q.push_back({6'(k), 32'h1111_0000 + k});
    begin
      logic [63:0] busy_exp [4];
      busy_exp[0] = 64'h1C;
      busy_exp[1] = 64'h18;
      busy_exp[2] = 64'h10;
      busy_exp[3] = 64'h00;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("drain_wen", {63'h0, bus_if.wen_o}, 64'h1);
        chk("drain_busy", bus_if.busy_o, busy_exp[k]);
        chk("drain_count", {61'h0, bus_if.count_o}, 64'(3 - k));
      end
    end
    tick();

    // Pop and enqueue in the same cycle
    alu(1'b1, 6'd41, 32'hB000_0001);
    mc(1'b1, 6'd10, 32'h0000_0010);
    tick();
    alu(1'b1, 6'd42, 32'hB000_0002);
    mc(1'b1, 6'd11, 32'h0000_0011);
    tick();
    chk("two_count", {61'h0, bus_if.count_o}, 64'h2);
    alu(1'b0, 6'd0, 32'h0);
    mc(1'b1, 6'd12, 32'h0000_0012);
    exp_q.push_back({6'd10, 32'h0000_0010});
    exp_q.push_back({6'd11, 32'h0000_0011});
    exp_q.push_back({6'd12, 32'h0000_0012});
    tick();
    chk("popenq_count", {61'h0, bus_if.count_o}, 64'h2);
    chk("popenq_busy", bus_if.busy_o, 64'h1800);
    mc(1'b0, 6'd0, 32'h0);
    tick();
    tick();
    chk("popenq_empty", {61'h0, bus_if.count_o}, 64'h0);
    tick();

    // Reset mid-queue discards entries
    for (int c = 0; c < 3; c++) begin
      alu(1'b1, 6'(50 + c), 32'hC000_0000 + c);
      mc(1'b1, 6'(20 + c), 32'hDEAD_0000 + c);
      tick();
    end
    chk("pre_rst_count", {61'h0, bus_if.count_o}, 64'h3);
    alu(1'b0, 6'd0, 32'h0);
    mc(1'b0, 6'd0, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", {63'h0, bus_if.mc_ready_o}, 64'h0);
    tick();
    chk("midrst_count", {61'h0, bus_if.count_o}, 64'h0);
    chk("midrst_busy", bus_if.busy_o, 64'h0);
    chk("midrst_wen", {63'h0, bus_if.wen_o}, 64'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("postrst_count", {61'h0, bus_if.count_o}, 64'h0);

    // Starvation under continuous ALU writes
    alu(1'b1, 6'd60, 32'hE000_0000);
    mc(1'b1, 6'd30, 32'h3000_0030);
    tick();
    mc(1'b0, 6'd0, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      alu(1'b1, 6'd61, 32'hE000_0000 + k);
      tick();
    end
    chk("hold_early", {63'h0, bus_if.alu_hold_o}, 64'h0);
    alu(1'b1, 6'd61, 32'hE000_0008);
    tick();
`ifdef WB_STARVE_GUARD_EN
    chk("hold_set", {63'h0, bus_if.alu_hold_o}, 64'h1);
`else
    chk("hold_off", {63'h0, bus_if.alu_hold_o}, 64'h0);
`endif
    chk("starve_busy", bus_if.busy_o, 64'h4000_0000);
    alu(1'b0, 6'd0, 32'h0);
    exp_q.push_back({6'd30, 32'h3000_0030});
    tick();
    chk("starve_pop_wen", {63'h0, bus_if.wen_o}, 64'h1);
    chk("starve_pop_count", {61'h0, bus_if.count_o}, 64'h0);
    tick();
    chk("hold_clear", {63'h0, bus_if.alu_hold_o}, 64'h0);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back arbiter and buffer feeding the register file's single synchronous write port (wen/wa/write data).
- Single-cycle ALU results take priority every cycle. Results from multi-cycle units (load, multiply) are enqueued in a small in-order FIFO and drained on cycles with no ALU write.
- Exports a per-register busy vector so issue logic can hold dependent instructions until their queued write lands.

Parameters:
addr_width_p, 6, register address width; must match the register file
depth_p, 4, FIFO entries; power of two, >= 2
starve_limit_p, 8, consecutive blocked cycles before hold request (optional feature only)

Ports:
clk  input  1  clock; all state updates on posedge
reset_n_i  input  1  synchronous, active-low reset
alu_wen_i  input  1  ALU write request this cycle; always accepted
alu_wa_i  input  addr_width_p  ALU destination register
alu_data_i  input  32  ALU result
mc_valid_i  input  1  multi-cycle unit result valid
mc_wa_i  input  addr_width_p  multi-cycle destination register
mc_data_i  input  32  multi-cycle result
mc_ready_o  output  1  queue can accept; transfer when mc_valid_i && mc_ready_o
wen_o  output  1  register file write enable (registered)
wa_o  output  addr_width_p  register file write address (registered)
write_data_o  output  32  register file write data (registered)
busy_o  output  2**addr_width_p  bit a set while any valid FIFO entry targets register a
count_o  output  $clog2(depth_p)+1  current FIFO occupancy
alu_hold_o  output  1  request upstream to suppress ALU writes next cycle

Behaviour:
- Reset: sampled on posedge when reset_n_i=0. wen_o=0, wa_o=0, write_data_o=0, count_o=0, busy_o=0, alu_hold_o=0, FIFO pointers=0. mc_ready_o=0 while reset_n_i=0. Reset mid-drain discards all queued entries without writing them.
- mc_ready_o = (count_o != depth_p), combinational. No enqueue-while-full, even if a pop occurs the same cycle.
- Arbitration, each cycle t, in priority order. The chosen write appears on wen_o/wa_o/write_data_o at t+1 for exactly one cycle:
  1. alu_wen_i=1: output register loads ALU write. Queue head is not popped.
  2. else count_o>0: pop head into output register. A simultaneous mc enqueue still goes to the tail.
  3. else (empty) and mc_valid_i: bypass; mc result goes straight to the output register, not enqueued. Latency 1, count unchanged.
  4. else: wen_o=0 at t+1; wa_o/write_data_o hold their last values.
- Enqueue when mc_valid_i && mc_ready_o and not taken by bypass: write the tail entry and increment tail (wraps mod depth_p).
- count_o update: +1 on enqueue, -1 on pop, unchanged on both or neither.
- Pointer wrap: head/tail are log2(depth_p) bits wrapping naturally; full/empty come from count, never from pointer compare.
- Ordering: mc results leave in arrival order. ALU writes can overtake queued writes, including to the same address. Issue logic must not issue an ALU op whose destination has busy_o set. The block does not detect this case.
- busy_o: combinational OR over valid entries of one-hot(wa). It does not include the output register or the bypass path; those writes commit at t+1, the same edge a reader would see them.
- Worst-case queued latency is unbounded under continuous ALU writes, unless the optional feature is enabled.

Optional Feature:
Macro WB_STARVE_GUARD_EN.
- Defined:
  - A counter counts consecutive cycles with count_o>0 and alu_wen_i=1.
  - When the counter reaches starve_limit_p, alu_hold_o=1 (registered). It stays high until the head pops, then clears together with the counter.
  - ALU still wins if alu_wen_i=1 despite the hold; the hold is advisory.
  - Reset clears the counter.
- Undefined: alu_hold_o tied to 0; no counter logic.

Test Plan:
- Reset, then idle 3 cycles -> wen_o=0, count_o=0, busy_o=0, mc_ready_o=1; mc_ready_o=0 during reset cycles.
- Empty queue, mc_valid_i=1, mc_wa_i=5, mc_data_i=0xDEADBEEF, alu_wen_i=0 -> next cycle wen_o=1, wa_o=5, data 0xDEADBEEF; count_o stays 0.
- alu_wen_i=1 for 6 cycles while 4 mc writes to regs 1..4 arrive back-to-back:
  - count_o reaches 4, mc_ready_o=0, busy_o bits 1..4 set.
  - After ALU stops: writes to regs 1,2,3,4 appear on consecutive cycles in order.
  - busy_o clears each bit as its entry pops.
- Queue holds 2 entries; same cycle: alu_wen_i=0 and mc_valid_i=1 -> head written next cycle, new entry appended, count_o stays 2.
- Fill queue to 3, assert reset_n_i=0 for one cycle -> no queued write ever appears; count_o=0, busy_o=0.
- WB_STARVE_GUARD_EN, starve_limit_p=8: one entry queued, alu_wen_i=1 continuously -> alu_hold_o=1 after 8 cycles. Drop alu_wen_i -> entry written next cycle, alu_hold_o=0 the cycle after.
